// File: rtl/sync_gen_pkg.sv
// ----------------------------------------------------------------------------
// sync_gen_pkg
// Shared types and constants for the trigger sync link transmitter.
//   SYNC_GEN_STATE  : one-hot state encoding of the trigger FSM
//   MIN_HALF_PERIOD : smallest usable sync_pulse half period (ref_clk ticks)
//   GUARD_WRAPS     : divider wraps trigger_line is held low after a trigger
// ----------------------------------------------------------------------------
package sync_gen_pkg;

    typedef enum logic [3:0] {
        GEN_IDLE   = 4'd1,
        GEN_ARMED  = 4'd2,
        GEN_ACTIVE = 4'd4,
        GEN_GUARD  = 4'd8
    } SYNC_GEN_STATE;

    localparam int MIN_HALF_PERIOD = 2;
    localparam int GUARD_WRAPS     = 2;

endpackage

// File: rtl/sync_pulse_div.sv
// ----------------------------------------------------------------------------
// sync_pulse_div
// Divides ref_clk into the sync_pulse clock (idles high, 50% duty).
// Ports:
//   clk_i          ref_clk
//   rst_ni         asynchronous active-low reset
//   enable_i       run the divider; low holds div_cnt at 0 and sync_pulse at 1
//   half_period_i  requested half period in ticks (values below 2 act as 2)
//   sync_pulse_o   divided clock
//   div_cnt_o      position inside the current half period
//   hp_eff_o       half period currently in force
//   wrap_evt_o     div_cnt is at its last tick; the next edge toggles sync_pulse
//   fall_evt_o     wrap during the high phase; sync_pulse reads 0 next cycle
// ----------------------------------------------------------------------------
module sync_pulse_div
    import sync_gen_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] half_period_i,
    output logic                 sync_pulse_o,
    output logic [DIV_WIDTH-1:0] div_cnt_o,
    output logic [DIV_WIDTH-1:0] hp_eff_o,
    output logic                 wrap_evt_o,
    output logic                 fall_evt_o
);

    function automatic logic [DIV_WIDTH-1:0] sat_half(input logic [DIV_WIDTH-1:0] hp);
        if (hp < DIV_WIDTH'(MIN_HALF_PERIOD)) begin
            return DIV_WIDTH'(MIN_HALF_PERIOD);
        end
        return hp;
    endfunction

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] hp_eff_q, hp_eff_d;
    logic                 sync_q, sync_d;
    logic                 loaded_q;
    logic                 run;
    logic                 wrap;

    // The first cycle after reset release is spent loading hp_eff, so the
    // counter always starts against a freshly latched half period.
    assign run  = enable_i & loaded_q;
    assign wrap = run & (div_cnt_q == hp_eff_q - DIV_WIDTH'(1));

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        sync_d    = sync_q;
        hp_eff_d  = hp_eff_q;
        if (!run) begin
            div_cnt_d = '0;
            sync_d    = 1'b1;
            hp_eff_d  = sat_half(half_period_i);
        end else if (wrap) begin
            div_cnt_d = '0;
            sync_d    = ~sync_q;
            hp_eff_d  = sat_half(half_period_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            hp_eff_q  <= DIV_WIDTH'(MIN_HALF_PERIOD);
            sync_q    <= 1'b1;
            loaded_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hp_eff_q  <= hp_eff_d;
            sync_q    <= sync_d;
            loaded_q  <= 1'b1;
        end
    end

    assign sync_pulse_o = sync_q;
    assign div_cnt_o    = div_cnt_q;
    assign hp_eff_o     = hp_eff_q;
    assign wrap_evt_o   = wrap;
    assign fall_evt_o   = wrap & sync_q;

endmodule

// File: rtl/sync_trigger_gen.sv
// ----------------------------------------------------------------------------
// sync_trigger_gen
// Transmit end of the trigger sync link. Produces the sync_pulse clock and, on
// request, raises trigger_line ahead of a sync_pulse falling edge, holds it
// for a programmed number of sync periods, then keeps it low for one full
// guard period before accepting another request.
// Ports:
//   ref_clk, rst_n        clock, asynchronous active-low reset
//   enable                run divider; low stops it and aborts any trigger
//   half_period           sync_pulse half period in ticks (min 2)
//   lead_ticks            arming lead ahead of the falling edge
//   hold_periods          falling edges trigger_line stays high (0 acts as 1)
//   trig_req              launch request
//   trig_ack              1-cycle pulse, request accepted
//   req_overrun           1-cycle pulse per cycle trig_req is seen while busy
//   sync_pulse            divided clock, idles high
//   trigger_line          trigger to the receivers
//   busy                  FSM not idle
//   trig_count            triggers launched, wraps; cleared only by rst_n
// ----------------------------------------------------------------------------
module sync_trigger_gen
    import sync_gen_pkg::*;
#(
    parameter int DIV_WIDTH  = 8,
    parameter int HOLD_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  half_period,
    input  logic [DIV_WIDTH-1:0]  lead_ticks,
    input  logic [HOLD_WIDTH-1:0] hold_periods,
    input  logic                  trig_req,
    output logic                  trig_ack,
    output logic                  req_overrun,
    output logic                  sync_pulse,
    output logic                  trigger_line,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  trig_count
);

    function automatic logic [DIV_WIDTH-1:0] clamp_lead(input logic [DIV_WIDTH-1:0] lead,
                                                        input logic [DIV_WIDTH-1:0] lim);
        return (lead > lim) ? lim : lead;
    endfunction

    function automatic logic [HOLD_WIDTH-1:0] hold_floor(input logic [HOLD_WIDTH-1:0] h);
        return (h == '0) ? HOLD_WIDTH'(1) : h;
    endfunction

    logic [DIV_WIDTH-1:0]  div_cnt, hp_eff, hp_m1, lead_use, arm_pt;
    logic                  wrap_evt, fall_evt, arm_hit;

    SYNC_GEN_STATE         state_q;
    logic [DIV_WIDTH-1:0]  lead_eff_q;
    logic [HOLD_WIDTH-1:0] hold_eff_q, hold_cnt_q;
    logic [1:0]            guard_cnt_q;
    logic                  trig_line_q, ack_q, ovr_q, busy_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    sync_pulse_div #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk_i         (ref_clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .half_period_i (half_period),
        .sync_pulse_o  (sync_pulse),
        .div_cnt_o     (div_cnt),
        .hp_eff_o      (hp_eff),
        .wrap_evt_o    (wrap_evt),
        .fall_evt_o    (fall_evt)
    );

    // Lead is re-clamped against the live half period so a shorter period
    // loaded at a wrap can never push the arming point out of range.
    assign hp_m1    = hp_eff - DIV_WIDTH'(1);
    assign lead_use = clamp_lead(lead_eff_q, hp_m1);
    assign arm_pt   = hp_m1 - lead_use;
    assign arm_hit  = sync_pulse & (div_cnt == arm_pt);

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GEN_IDLE;
            trig_line_q <= 1'b0;
            ack_q       <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            lead_eff_q  <= '0;
            hold_eff_q  <= HOLD_WIDTH'(1);
            hold_cnt_q  <= '0;
            guard_cnt_q <= '0;
        end else begin
            ack_q <= 1'b0;
            ovr_q <= 1'b0;
            if (!enable) begin
                // Abort: everything but trig_count returns to idle.
                state_q     <= GEN_IDLE;
                trig_line_q <= 1'b0;
                busy_q      <= 1'b0;
                hold_cnt_q  <= '0;
                guard_cnt_q <= '0;
            end else begin
                if (trig_req && state_q != GEN_IDLE) begin
                    ovr_q <= 1'b1;
                end
                case (state_q)
                    GEN_IDLE: begin
                        if (trig_req) begin
                            state_q    <= GEN_ARMED;
                            busy_q     <= 1'b1;
                            ack_q      <= 1'b1;
                            lead_eff_q <= clamp_lead(lead_ticks, hp_m1);
                            hold_eff_q <= hold_floor(hold_periods);
                        end
                    end
                    GEN_ARMED: begin
                        if (arm_hit) begin
                            state_q     <= GEN_ACTIVE;
                            trig_line_q <= 1'b1;
                            cnt_q       <= cnt_q + CNT_WIDTH'(1);
                            hold_cnt_q  <= '0;
                        end
                    end
                    GEN_ACTIVE: begin
                        if (fall_evt) begin
                            if (hold_cnt_q == hold_eff_q - HOLD_WIDTH'(1)) begin
                                state_q     <= GEN_GUARD;
                                trig_line_q <= 1'b0;
                                guard_cnt_q <= '0;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + HOLD_WIDTH'(1);
                            end
                        end
                    end
                    GEN_GUARD: begin
                        if (wrap_evt) begin
                            if (guard_cnt_q == 2'(GUARD_WRAPS - 1)) begin
                                state_q <= GEN_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                guard_cnt_q <= guard_cnt_q + 2'd1;
                            end
                        end
                    end
                    default: begin
                        state_q     <= GEN_IDLE;
                        busy_q      <= 1'b0;
                        trig_line_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign trigger_line = trig_line_q;
    assign trig_ack     = ack_q;
    assign req_overrun  = ovr_q;
    assign busy         = busy_q;
    assign trig_count   = cnt_q;

endmodule

// File: tb/tb_sync_trigger_gen.sv
// ----------------------------------------------------------------------------
// tb_sync_trigger_gen
// Directed scenarios followed by randomized traffic. A timeline model predicts
// every output: sync_pulse from elapsed ticks since enable, and each accepted
// request as a set of absolute edge times (arm, release, end of guard).
// A second instance with a 4-bit trig_count shares all inputs to expose the
// counter wrap in a short run.
// ----------------------------------------------------------------------------
module tb_sync_trigger_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  half_period;
    logic [7:0]  lead_ticks;
    logic [7:0]  hold_periods;
    logic        trig_req;
    logic        trig_ack, req_overrun, sync_pulse, trigger_line, busy;
    logic [15:0] trig_count;
    logic        w_ack, w_ovr, w_sync, w_trig, w_busy;
    logic [3:0]  w_count;

    always #5 clk = ~clk;

    sync_trigger_gen #(.DIV_WIDTH(8), .HOLD_WIDTH(8), .CNT_WIDTH(16)) dut (
        .ref_clk      (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .half_period  (half_period),
        .lead_ticks   (lead_ticks),
        .hold_periods (hold_periods),
        .trig_req     (trig_req),
        .trig_ack     (trig_ack),
        .req_overrun  (req_overrun),
        .sync_pulse   (sync_pulse),
        .trigger_line (trigger_line),
        .busy         (busy),
        .trig_count   (trig_count)
    );

    sync_trigger_gen #(.DIV_WIDTH(8), .HOLD_WIDTH(8), .CNT_WIDTH(4)) dut_w (
        .ref_clk      (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .half_period  (half_period),
        .lead_ticks   (lead_ticks),
        .hold_periods (hold_periods),
        .trig_req     (trig_req),
        .trig_ack     (w_ack),
        .req_overrun  (w_ovr),
        .sync_pulse   (w_sync),
        .trigger_line (w_trig),
        .busy         (w_busy),
        .trig_count   (w_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_run;
    int          m_n;            // edge index since the first enabled edge
    int          m_hp, m_lead, m_hold;
    bit          m_busy;
    int          m_tarm, m_tfall, m_tend;
    logic        m_sync, m_trig, m_ack, m_ovr;
    logic [15:0] m_cnt;

    // The cycle closing edge k sees the divider in the high phase when
    // floor(k/hp) is even, at position k mod hp within the half period.
    function automatic bit is_hi(input int k, input int hp);
        return ((k / hp) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_n = 0; m_hp = 2; m_busy = 0;
        m_sync = 1; m_trig = 0; m_ack = 0; m_ovr = 0; m_cnt = '0;
        m_tarm = -1; m_tfall = -1; m_tend = -1;
    endtask

    task automatic model_edge();
        int k, f;
        m_ack = 0;
        m_ovr = 0;
        if (!enable) begin
            m_run  = 0;
            m_hp   = (half_period < 8'd2) ? 2 : int'(half_period);
            m_busy = 0;
            m_trig = 0;
            m_sync = 1;
            return;
        end
        if (!m_run) begin
            m_run = 1;
            m_n   = 0;
        end else begin
            m_n++;
        end
        if (!m_busy) begin
            if (trig_req) begin
                m_busy = 1;
                m_ack  = 1;
                m_lead = (int'(lead_ticks) > m_hp - 1) ? m_hp - 1 : int'(lead_ticks);
                m_hold = (hold_periods == 8'd0) ? 1 : int'(hold_periods);
                // Arm: first later high-phase cycle at position hp-1-lead.
                k = m_n + 1;
                while (!((k % m_hp) == m_hp - 1 - m_lead && is_hi(k, m_hp))) k++;
                m_tarm = k;
                // Release: the hold-th sync falling edge after arming.
                f = 0;
                while (f < m_hold) begin
                    k++;
                    if ((k % m_hp) == m_hp - 1 && is_hi(k, m_hp)) f++;
                end
                m_tfall = k;
                m_tend  = k + 2 * m_hp;
            end
        end else begin
            if (trig_req) m_ovr = 1;
            if (m_n == m_tarm) begin
                m_trig = 1;
                m_cnt  = m_cnt + 16'd1;
            end
            if (m_n == m_tfall) m_trig = 0;
            if (m_n == m_tend)  m_busy = 0;
        end
        m_sync = is_hi(m_n + 1, m_hp);
    endtask

    task automatic compare_all();
        check_eq("sync_pulse",   sync_pulse,   m_sync);
        check_eq("trigger_line", trigger_line, m_trig);
        check_eq("trig_ack",     trig_ack,     m_ack);
        check_eq("req_overrun",  req_overrun,  m_ovr);
        check_eq("busy",         busy,         m_busy);
        check_eq("trig_count",   trig_count,   m_cnt);
        check_eq("w_count",      w_count,      m_cnt[3:0]);
        check_eq("w_flags", {w_sync, w_trig, w_ack, w_ovr, w_busy},
                            {m_sync, m_trig, m_ack, m_ovr, m_busy});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_sync"}, sync_pulse, 1'b1);
        check_eq({tag, "_trig"}, trigger_line, 1'b0);
        check_eq({tag, "_ack"},  trig_ack, 1'b0);
        check_eq({tag, "_ovr"},  req_overrun, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_cnt"},  trig_count, 16'd0);
        check_eq({tag, "_wcnt"}, w_count, 4'd0);
    endtask

    // sel: 0 sync_pulse, 1 trigger_line, 2 busy
    task automatic wait_for(input string tag, input int sel, input logic val,
                            input int limit, output int n);
        logic cur;
        n = 0;
        while (1) begin
            case (sel)
                0:       cur = sync_pulse;
                1:       cur = trigger_line;
                default: cur = busy;
            endcase
            if (cur === val) break;
            if (n >= limit) begin
                check_eq({tag, "_timeout"}, 32'(cur), 32'(val));
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic pulse_req();
        trig_req = 1'b1;
        step();
        trig_req = 1'b0;
    endtask

    task automatic restart(input logic [7:0] hp);
        enable = 1'b0;
        half_period = hp;
        step();
        step();
        enable = 1'b1;
    endtask

    int          c, c0;
    logic [15:0] target;

    initial begin
        rst_n = 1'b0; enable = 1'b0; trig_req = 1'b0;
        half_period = 8'd5; lead_ticks = 8'd0; hold_periods = 8'd1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        step();
        step();

        // Divider: hp=5 -> first fall 5 cycles after enable, 5 low / 5 high.
        restart(8'd5);
        wait_for("t1_first", 0, 1'b0, 50, c);  check_eq("t1_first_fall", c, 5);
        wait_for("t1_lo", 0, 1'b1, 50, c);     check_eq("t1_low_phase", c, 5);
        wait_for("t1_hi", 0, 1'b0, 50, c);     check_eq("t1_high_phase", c, 5);

        // Single trigger, lead 3, hold 2. trigger_line goes high on the edge
        // closing the arm_hit cycle; sync_pulse falls lead_eff edges later,
        // so arm_hit itself sits lead_eff+1 cycles before sync reads low.
        lead_ticks = 8'd3; hold_periods = 8'd2;
        c0 = trig_count;
        pulse_req();
        check_eq("t2_ack", trig_ack, 1'b1);
        wait_for("t2_rise", 1, 1'b1, 50, c);
        check_eq("t2_sync_high_at_rise", sync_pulse, 1'b1);
        wait_for("t2_lead", 0, 1'b0, 50, c);   check_eq("t2_lead_gap", c, 3);
        wait_for("t2_hold", 1, 1'b0, 50, c);   check_eq("t2_hold_len", c, 10);
        check_eq("t2_sync_low_at_release", sync_pulse, 1'b0);
        check_eq("t2_count", trig_count, 16'(c0 + 1));
        wait_for("t2_idle", 2, 1'b0, 50, c);   check_eq("t2_guard_len", c, 10);

        // half_period 0 and 1 behave as 2.
        restart(8'd0);
        wait_for("t3a_first", 0, 1'b0, 20, c); check_eq("t3a_first_fall", c, 2);
        wait_for("t3a_lo", 0, 1'b1, 20, c);    check_eq("t3a_low", c, 2);
        restart(8'd1);
        wait_for("t3b_first", 0, 1'b0, 20, c); check_eq("t3b_first_fall", c, 2);
        wait_for("t3b_hi", 0, 1'b1, 20, c);
        wait_for("t3b_lo", 0, 1'b0, 20, c);    check_eq("t3b_high", c, 2);
        // lead 9 with half period 4 clamps to 3: arm as sync first reads 1.
        restart(8'd4);
        lead_ticks = 8'd9; hold_periods = 8'd1;
        pulse_req();
        wait_for("t3c_rise", 1, 1'b1, 50, c);
        wait_for("t3c_lead", 0, 1'b0, 50, c);  check_eq("t3c_lead_gap", c, 3);
        wait_for("t3c_idle", 2, 1'b0, 80, c);

        // Overrun while ARMED and while in GUARD.
        lead_ticks = 8'd1; hold_periods = 8'd3;
        c0 = trig_count;
        pulse_req();
        pulse_req();
        check_eq("t4_ovr_armed", req_overrun, 1'b1);
        wait_for("t4_rise", 1, 1'b1, 50, c);
        wait_for("t4_fall", 1, 1'b0, 80, c);
        check_eq("t4_in_guard", busy, 1'b1);
        pulse_req();
        check_eq("t4_ovr_guard", req_overrun, 1'b1);
        wait_for("t4_idle", 2, 1'b0, 80, c);
        repeat (10) step();
        check_eq("t4_count", trig_count, 16'(c0 + 1));

        // Abort by enable, then asynchronous reset mid-ACTIVE.
        restart(8'd3);
        lead_ticks = 8'd1; hold_periods = 8'd3;
        c0 = trig_count;
        pulse_req();
        wait_for("t5_rise", 1, 1'b1, 50, c);
        enable = 1'b0;
        step();
        check_eq("t5_abort_trig", trigger_line, 1'b0);
        check_eq("t5_abort_busy", busy, 1'b0);
        check_eq("t5_abort_sync", sync_pulse, 1'b1);
        check_eq("t5_abort_count", trig_count, 16'(c0 + 1));
        restart(8'd3);
        pulse_req();
        wait_for("t5b_rise", 1, 1'b1, 50, c);
        #2;
        rst_n = 1'b0; enable = 1'b0; trig_req = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Held request, hold 0: back-to-back triggers; 4-bit count wraps.
        lead_ticks = 8'($urandom_range(0, 3));
        hold_periods = 8'd0;
        restart(8'd2);
        trig_req = 1'b1;
        target = trig_count + 16'd17;
        c = 0;
        while (trig_count !== target && c < 3000) begin
            step();
            c++;
        end
        check_eq("t6_count", trig_count, target);
        check_eq("t6_wcount", w_count, target[3:0]);
        trig_req = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                trig_req = 1'b0;
                restart(8'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 15) == 0) lead_ticks   = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) hold_periods = 8'($urandom_range(0, 3));
            trig_req = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
